// File: rtl/counter_updown_mod.sv
// counter_updown_mod: parametrised synchronous up/down modulo counter.
//
// Counts over 0..MODULUS-1 in either direction, with a count enable, a synchronous
// parallel load (clamped to MODULUS-1), and a combinational terminal-count output.
// Stages cascade by driving the next stage's en from this stage's tc.
//
// Optional feature macro: COUNTER_UDM_SAT_EN
//   When defined, adds the sat port. With sat=1, an enabled edge at the terminal
//   value holds the count instead of wrapping. When undefined, the counter always
//   wraps and no saturation logic exists.
//
// Parameters:
//   WIDTH     counter width in bits (1..16)
//   MODULUS   number of states (2..2^WIDTH)
//   RESET_VAL value forced by reset (< MODULUS)
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-high reset, forces o = RESET_VAL
//   en     in   count enable, one step per enabled edge
//   dir    in   1 = count up, 0 = count down
//   load   in   synchronous load of d, wins over en
//   d      in   load value [WIDTH-1:0]
//   sat    in   saturate instead of wrap (only with COUNTER_UDM_SAT_EN)
//   o      out  registered count [WIDTH-1:0]
//   tc     out  terminal count, combinational from o, en, dir, load

module counter_updown_mod #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MODULUS   = 16,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
`ifdef COUNTER_UDM_SAT_EN
  input  logic             sat,
`endif
  output logic [WIDTH-1:0] o,
  output logic             tc
);

  // MODULUS may equal 2^WIDTH, so MODULUS-1 always fits in WIDTH bits.
  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RstVal = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] count_q, count_d;
  logic             at_max, at_zero, at_term;
  logic             d_in_range;

  // Explicit compares keep non-power-of-two moduli identical to power-of-two ones.
  assign at_max  = (count_q == MaxVal);
  assign at_zero = (count_q == '0);
  assign at_term = dir ? at_max : at_zero;

  // Compare in 32 bits so MODULUS = 2^WIDTH does not truncate to zero.
  assign d_in_range = (32'(d) < MODULUS);

  assign tc = en & ~load & at_term;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = d_in_range ? d : MaxVal;
    end else if (en) begin
      if (at_term) begin
`ifdef COUNTER_UDM_SAT_EN
        if (sat) begin
          count_d = count_q;
        end else begin
          count_d = dir ? '0 : MaxVal;
        end
`else
        count_d = dir ? '0 : MaxVal;
`endif
      end else begin
        count_d = dir ? (count_q + WIDTH'(1)) : (count_q - WIDTH'(1));
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= RstVal;
    end else begin
      count_q <= count_d;
    end
  end

  assign o = count_q;

endmodule

// File: doc/counter_updown_mod.md
# counter_updown_mod

Parametrised synchronous up/down modulo counter, the general successor to the fixed 4-bit down counter used in the lab display and timing paths. It supports configurable width and modulus, runtime count direction, count enable, parallel load, and a terminal-count output for cascading stages. Typical uses are the seven-segment scan, clock-divider and stopwatch datapaths, where several instances are chained through `tc` → `en`.

## Interface
Parameters:
- `WIDTH`, default 4: counter width in bits; legal range 1..16.
- `MODULUS`, default 16: number of states; count range is 0..MODULUS-1; legal range 2..2^WIDTH.
- `RESET_VAL`, default 0: value loaded on reset; must be < MODULUS.

Ports:
- `clk`  in  1: rising-edge clock.
- `reset`  in  1: asynchronous, active-high reset.
- `en`  in  1: count enable; advances one step per enabled cycle.
- `dir`  in  1: direction; 1 = up, 0 = down.
- `load`  in  1: synchronous parallel load of `d`.
- `d`  in  WIDTH: load value.
- `sat`  in  1: saturate instead of wrap. Present only when `COUNTER_UDM_SAT_EN` is defined.
- `o`  out  WIDTH: registered count.
- `tc`  out  1: terminal count, combinational from `o`, `en`, `dir` and `load`.

## Operation
- **Reset:**
  - `reset`=1 forces `o`=RESET_VAL immediately, with no dependence on `clk`.
  - The count holds at RESET_VAL while `reset` is high.
  - `tc` follows its normal equation, so with the default parameters it is 0 unless `en`=1, `dir`=0 and `load`=0.
- **Priority** at each rising edge: `reset` > `load` > `en`. With `en`=0 and `load`=0, `o` holds.
- **Load:**
  - `o` ← `d` when `d` < MODULUS.
  - Otherwise `o` ← MODULUS-1 (clamp).
  - `load` is honoured regardless of `en` and `dir`.
- **Up count** (`dir`=1): `o` ← `o`+1; when `o`=MODULUS-1, `o` ← 0 (wrap).
- **Down count** (`dir`=0): `o` ← `o`-1; when `o`=0, `o` ← MODULUS-1 (wrap).
- **Arithmetic:**
  - Next-state arithmetic is done in WIDTH bits, with explicit compares against MODULUS-1 and 0.
  - The compares must not depend on natural 2^WIDTH overflow, so non-power-of-two moduli behave identically to power-of-two ones.
- **Terminal count:**
  - `tc` = `en` & ~`load` & ((`dir` & `o`==MODULUS-1) | (~`dir` & `o`==0)).
  - `tc` is high exactly in the cycle whose rising edge performs the wrap, or the saturating hold.
  - Cascade by connecting `tc` of stage n to `en` of stage n+1.
- **Direction change:**
  - `dir` may change on any cycle.
  - The new direction applies from the next rising edge.
  - There is no turnaround penalty and no skipped value.

## Timing
- Count latency: `o` updates one cycle after an enabled edge.
- Load latency: `d` appears on `o` one cycle after the edge sampling `load`=1.
- `tc` is combinational with zero latency. Downstream logic must register it, or use it only as an enable in the same clock domain.
- **Reset assertion** mid-count:
  - `o` goes to RESET_VAL asynchronously; any pending load or count is discarded.
  - On release, the first rising edge with `reset`=0 resumes normal operation from RESET_VAL.
- Inputs `en`, `dir`, `load`, `d` and `sat` are synchronous to `clk` and must meet setup/hold.
- Throughput: one step per cycle; there is no throughput limit.

## Configuration
- Macro `COUNTER_UDM_SAT_EN`.
- **Defined:**
  - Adds port `sat`.
  - With `sat`=1 at the terminal value (MODULUS-1 counting up, 0 counting down), an enabled edge holds `o` instead of wrapping.
  - `tc` stays asserted for every such enabled cycle.
  - Moving away from the terminal value (reversed `dir`) and `load` work as normal.
  - With `sat`=0, behaviour is identical to the wrap mode.
- **Undefined:**
  - No `sat` port; the counter always wraps.
  - No saturation logic is synthesised.

## Test plan
- **Reset:** WIDTH=4, MODULUS=10, RESET_VAL=3. Assert `reset` mid-cycle while counting at 7 → `o`=3 before the next clock edge. Release `reset`, then `en`=1, `dir`=1 → `o` reads 4, 5 on successive cycles.
- **Up wrap with non-power-of-two modulus:** MODULUS=10, count up from 0 → sequence 0…9, 0. `tc`=1 only in the cycle where `o`=9 with `en`=1.
- **Down wrap:** MODULUS=16, start at 1, count down → 1, 0, 15, 14. `tc`=1 only while `o`=0.
- **Load priority and clamp:** MODULUS=10. `load`=1, `en`=1, `d`=5 → `o`=5 and `tc`=0 that cycle. `d`=12 → `o`=9.
- **Direction flip and hold:**
  - At `o`=6 with `en`=1: toggle `dir` 1→0 → `o` reads 7, then 6.
  - `en`=0 for 3 cycles → `o` stays 6.
  - Two MODULUS=10 stages cascaded via `tc` count 00→99→00.
- **Saturation** (`COUNTER_UDM_SAT_EN` defined): `sat`=1, MODULUS=10, count up to 9 → `o` holds at 9 for 3 enabled cycles with `tc`=1 throughout. Set `dir`=0 → `o`=8.
